// File: rtl/l2_bus_ctrl.sv
// Bus-side controller for L2 line requests: arbitrates, issues one command,
// resolves the snoop/ack into a final MESI state and retries on HITM.
module l2_bus_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int OFFSET_W  = 6,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_valid,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [1:0]        bus_snoop,
  output logic              done,
  output logic [1:0]        done_state,
  output logic              done_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RFO  = 2'b01;
  localparam logic [1:0] OP_WB   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;
  localparam logic [1:0] SN_HIT  = 2'b01;
  localparam logic [1:0] SN_HITM = 2'b10;
  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    ADDR     = 3'd2,
    WAIT_ACK = 3'd3,
    BACKOFF  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state_r;
  logic [1:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [RW-1:0]     retry_cnt_r;
  logic [TW-1:0]     tmo_cnt_r;

  logic              fin_s;
  logic              retry_s;
  logic [1:0]        fin_state_s;
  logic              fin_err_s;

  // Outcome of a WAIT_ACK cycle; an ack always beats a simultaneous timeout.
  always_comb begin
    fin_s       = 1'b0;
    retry_s     = 1'b0;
    fin_state_s = ST_I;
    fin_err_s   = 1'b0;
    if (bus_ack) begin
      case (op_r)
        OP_READ: begin
          if (bus_snoop == SN_HITM) begin
            retry_s = 1'b1;
          end else if (bus_snoop == SN_HIT) begin
            fin_s       = 1'b1;
            fin_state_s = ST_S;
          end else begin
            fin_s       = 1'b1;
            fin_state_s = ST_E;
          end
        end
        OP_RFO: begin
          if (bus_snoop == SN_HITM) begin
            retry_s = 1'b1;
          end else begin
            fin_s       = 1'b1;
            fin_state_s = ST_M;
          end
        end
        OP_WB: begin
          fin_s       = 1'b1;
          fin_state_s = ST_I;
        end
        OP_INV: begin
          fin_s       = 1'b1;
          fin_state_s = ST_M;
        end
        default: begin
          fin_s       = 1'b1;
          fin_state_s = ST_I;
        end
      endcase
      if (retry_s && (retry_cnt_r == RETRY_LAST)) begin
        retry_s     = 1'b0;
        fin_s       = 1'b1;
        fin_state_s = ST_I;
        fin_err_s   = 1'b1;
      end
    end else if (tmo_cnt_r == TMO_LAST) begin
      fin_s       = 1'b1;
      fin_state_s = ST_I;
      fin_err_s   = 1'b1;
    end else begin
      fin_s = 1'b0;
    end
  end

  // Request FSM with every output registered from the next-state decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 2'b00;
      addr_r      <= '0;
      retry_cnt_r <= '0;
      tmo_cnt_r   <= '0;
      req_ready   <= 1'b1;
      bus_req     <= 1'b0;
      bus_valid   <= 1'b0;
      bus_cmd     <= 2'b00;
      bus_addr    <= '0;
      done        <= 1'b0;
      done_state  <= ST_I;
      done_err    <= 1'b0;
    end else begin
      bus_valid  <= 1'b0;
      bus_cmd    <= 2'b00;
      bus_addr   <= '0;
      done       <= 1'b0;
      done_state <= ST_I;
      done_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r        <= req_op;
            addr_r      <= req_addr & LINE_MASK;
            retry_cnt_r <= '0;
            req_ready   <= 1'b0;
            bus_req     <= 1'b1;
            state_r     <= ARB;
          end else begin
            req_ready <= 1'b1;
            bus_req   <= 1'b0;
          end
        end
        ARB: begin
          if (bus_gnt) begin
            bus_valid <= 1'b1;
            bus_cmd   <= op_r;
            bus_addr  <= addr_r;
            state_r   <= ADDR;
          end
        end
        ADDR: begin
          tmo_cnt_r <= '0;
          state_r   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (fin_s) begin
            bus_req    <= 1'b0;
            done       <= 1'b1;
            done_state <= fin_state_s;
            done_err   <= fin_err_s;
            state_r    <= DONE;
          end else if (retry_s) begin
            retry_cnt_r <= retry_cnt_r + RW'(1);
            bus_req     <= 1'b0;
            state_r     <= BACKOFF;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        BACKOFF: begin
          bus_req <= 1'b1;
          state_r <= ARB;
        end
        DONE: begin
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          bus_req   <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/l2_bus_ctrl.md
Name: l2_bus_ctrl

Overview:
Bus-side controller directly downstream of the L2 cache trace engine. On a miss, eviction or upgrade, the L2 control flow hands it one line-level request (READ, RFO, WRITEBACK, INVALIDATE). The block arbitrates for the shared bus, issues the command, collects the snoop result and ack, then returns the final MESI state to the L2 for its DV/state write. The block handles one outstanding request at a time and retries when another cache reports HITM.

Parameters:
ADDR_W, 32, address width in bits
OFFSET_W, 6, line offset bits; zeroed on bus_addr
TIMEOUT, 255, max cycles spent in WAIT_ACK before an error completion
MAX_RETRY, 3, max HITM retries before an error completion

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  L2 request valid
req_ready  out  1  block can accept a request
req_op  in  2  00 READ, 01 RFO, 10 WRITEBACK, 11 INVALIDATE
req_addr  in  ADDR_W  byte address
bus_req  out  1  bus arbitration request
bus_gnt  in  1  bus grant
bus_valid  out  1  command/address phase strobe
bus_cmd  out  2  encoded as req_op
bus_addr  out  ADDR_W  line-aligned address
bus_ack  in  1  transaction complete
bus_snoop  in  2  00 NOHIT, 01 HIT, 10 HITM, 11 treated as NOHIT
done  out  1  one-cycle completion pulse
done_state  out  2  0 I, 1 S, 2 E, 3 M
done_err  out  1  qualifies done: timeout or retry exhaustion

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=1. All other outputs 0. Counters 0. Any in-flight transaction is abandoned and bus_req drops immediately.
- All outputs are Moore (registered state decode). No combinational paths from inputs to outputs.
- IDLE: req_ready=1. When req_valid=1, the block latches op and {addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, clears retry_cnt, and moves to ARB. req_ready=0 in every other state.
- ARB: bus_req=1. When bus_gnt=1 is sampled, move to ADDR. The block waits indefinitely for grant (no timeout). bus_ack is ignored in ARB.
- ADDR: exactly one cycle. bus_valid=1, bus_cmd and bus_addr driven, and bus_req stays 1. Clear the timeout counter, then move to WAIT_ACK.
- WAIT_ACK: bus_req=1. When bus_ack=1, sample bus_snoop in the same cycle and resolve as follows:
  - READ: NOHIT→E, HIT→S, HITM→retry.
  - RFO: NOHIT/HIT→M, HITM→retry.
  - WRITEBACK: →I; snoop ignored.
  - INVALIDATE: →M; snoop ignored.
  - Without ack, the timeout counter increments. When the counter equals TIMEOUT, move to DONE with err=1 and state I.
- Retry: go to BACKOFF for one cycle with bus_req=0, then return to ARB. Increment retry_cnt. If the HITM arrives with retry_cnt==MAX_RETRY already, move to DONE with err=1 and state I instead of retrying.
- DONE: done=1 for exactly one cycle, with done_state and done_err valid only while done=1 (0 otherwise). Then go to IDLE.
- Minimum latency: accept at edge 0, grant sampled in ARB, ADDR, ack in the first WAIT_ACK cycle. done=1 on the 4th cycle after the accept edge. The next request can be accepted in the cycle after done.
- bus_gnt deassertion after ADDR is ignored. A bus_ack arriving in the same cycle the timeout is reached takes priority: normal resolution, no error.
- States: IDLE, ARB, ADDR, WAIT_ACK, BACKOFF, DONE.

Test Plan:
- Reset mid-WAIT_ACK: drop rst_n asynchronously → bus_req=0 and req_ready=1 before the next clock edge; done never pulses.
- READ 0x0001_2345, gnt immediate, ack in 1st WAIT_ACK cycle with NOHIT → bus_addr=0x0001_2340, bus_cmd=00, bus_valid high for exactly 1 cycle, done on 4th cycle after accept, done_state=E, err=0. Repeat with HIT → S.
- RFO, HITM on first two acks, NOHIT on third → three ADDR phases, each BACKOFF cycle shows bus_req=0, done_state=M, err=0. HITM on four consecutive acks → done, err=1, state I after the 4th ADDR phase.
- WRITEBACK with bus_snoop=HITM → no retry, done_state=I, err=0. INVALIDATE with snoop HIT → done_state=M.
- Timeout: TIMEOUT=255 and ack never arrives → done with err=1 exactly 255 cycles into WAIT_ACK. Second run with ack on that exact cycle and snoop NOHIT on READ → done_state=E, err=0.
- Back-to-back: req_valid held high across two READs → second accepted on the cycle after done; req_ready=0 throughout the first transaction, including while bus_gnt is held low for 10 cycles in ARB.
